// File: rtl/pkg_config.sv
// Shared configuration for the load/store path: data width, LSU FSM states
// and the RV32I funct3 encodings for memory accesses.
package pkg_config;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ST_READ,
        ST_WRITE,
        RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/data_memory.sv
// Word-wide data memory: combinational read, write on the rising edge
// when the write enable is high.
module data_memory
    import pkg_config::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= data_i;
        end
    end

    assign data_o = mem[addr_i];

endmodule

// File: rtl/lsu_align.sv
// Combinational lane handling for the LSU: load lane select and extension,
// sub-word store merge, and misaligned/illegal request detection.
module lsu_align
    import pkg_config::*;
(
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [15:0]           wdata,
    input  logic [1:0]            addr,
    input  logic [2:0]            funct3,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [1:0]            req_addr,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] merged,
    output logic                  err
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = addr[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   load_data = {24'd0, byte_lane};
            F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
            F3_HU:   load_data = {16'd0, half_lane};
            default: load_data = word;
        endcase
    end

    // Only the addressed lane of the old word is replaced; SW never uses this.
    always_comb begin
        merged = word;
        if (funct3 == F3_B) begin
            case (addr)
                2'd0:    merged[7:0]   = wdata[7:0];
                2'd1:    merged[15:8]  = wdata[7:0];
                2'd2:    merged[23:16] = wdata[7:0];
                default: merged[31:24] = wdata[7:0];
            endcase
        end else if (funct3 == F3_H) begin
            if (addr[1]) begin
                merged[31:16] = wdata;
            end else begin
                merged[15:0] = wdata;
            end
        end
    end

    always_comb begin
        err = 1'b0;
        if (req_we) begin
            case (req_funct3)
                F3_B:    err = 1'b0;
                F3_H:    err = req_addr[0];
                F3_W:    err = |req_addr;
                default: err = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                F3_B, F3_BU: err = 1'b0;
                F3_H, F3_HU: err = req_addr[0];
                F3_W:        err = |req_addr;
                default:     err = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and data_memory: one request at a time,
// sub-word stores done as read-modify-write on the word-wide memory.
module load_store_unit
    import pkg_config::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  ready_o,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    lsu_state_t      state;
    logic [2:0]      funct3;
    logic [1:0]      addr_lo;
    logic [15:0]     wdata_lo;
    logic            mem_we;
    logic [31:0]     load_data;
    logic [31:0]     merged;
    logic            req_err;
    logic            unused_addr;

    assign unused_addr = ^addr_i[31:ADDR_W+2];

    lsu_align u_align (
        .word       (mem_rdata_i),
        .wdata      (wdata_lo),
        .addr       (addr_lo),
        .funct3     (funct3),
        .req_we     (we_i),
        .req_funct3 (funct3_i),
        .req_addr   (addr_i[1:0]),
        .load_data  (load_data),
        .merged     (merged),
        .err        (req_err)
    );

    assign ready_o = (state == IDLE) && !rst_i;

    // Reset arriving during ST_WRITE must suppress the pending memory write.
    assign mem_we_o = mem_we && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            funct3      <= 3'd0;
            addr_lo     <= 2'd0;
            wdata_lo    <= 16'd0;
            rdata_o     <= 32'd0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        funct3     <= funct3_i;
                        addr_lo    <= addr_i[1:0];
                        wdata_lo   <= wdata_i[15:0];
                        mem_addr_o <= addr_i[ADDR_W+1:2];
                        if (req_err) begin
                            state  <= RESP;
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                        end else if (!we_i) begin
                            state <= LOAD;
                        end else if (funct3_i == F3_W) begin
                            state       <= ST_WRITE;
                            mem_we      <= 1'b1;
                            mem_wdata_o <= wdata_i;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                LOAD: begin
                    rdata_o <= load_data;
                    done_o  <= 1'b1;
                    state   <= RESP;
                end
                ST_READ: begin
                    mem_wdata_o <= merged;
                    mem_we      <= 1'b1;
                    state       <= ST_WRITE;
                end
                ST_WRITE: begin
                    done_o <= 1'b1;
                    state  <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a real data_memory, with a
// queue of expected responses popped when each transaction completes.
module tb_load_store_unit;
    import pkg_config::*;

    localparam int ADDR_W = 10;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  req = 1'b0;
    logic                  we = 1'b0;
    logic [2:0]            funct3 = 3'd0;
    logic [31:0]           addr = 32'd0;
    logic [31:0]           wdata = 32'd0;
    logic                  ready;
    logic [31:0]           rdata;
    logic                  done;
    logic                  err;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wes;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata = 32'd0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .ready_o     (ready),
        .we_i        (we),
        .funct3_i    (funct3),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .done_o      (done),
        .err_o       (err),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    data_memory #(.ADDR_W(ADDR_W)) u_mem (
        .clk_i  (clk),
        .we_i   (mem_we),
        .addr_i (mem_addr),
        .data_i (mem_wdata),
        .data_o (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Queue the expected response, then present the request for one accept edge.
    task automatic apply_stimulus(input string tag, input logic st, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic [31:0] exp_rdata, input logic exp_err,
                                  input int exp_lat, input int exp_wes);
        exp_t e;
        if (!st && !exp_err) begin
            last_rdata = exp_rdata;
        end
        e.tag   = tag;
        e.rdata = last_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        e.wes   = exp_wes;
        sb.push_back(e);
        @(negedge clk);
        check({tag, " ready"}, 32'(ready), 32'd1);
        req    = 1'b1;
        we     = st;
        funct3 = f3;
        addr   = a;
        wdata  = d;
        @(posedge clk);
    endtask

    task automatic check_output();
        exp_t e;
        int   lat  = 0;
        int   wes  = 0;
        bit   seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            req = 1'b0;
            lat = i;
            if (mem_we) wes++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        e = sb.pop_front();
        check({e.tag, " done"},    32'(seen),   32'd1);
        check({e.tag, " latency"}, 32'(lat),    32'(e.lat));
        check({e.tag, " err"},     32'(err),    32'(e.err));
        check({e.tag, " rdata"},   rdata,       e.rdata);
        check({e.tag, " we_count"}, 32'(wes),   32'(e.wes));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready",     32'(ready),     32'd0);
        check("reset rdata",     rdata,          32'd0);
        check("reset done",      32'(done),      32'd0);
        check("reset err",       32'(err),       32'd0);
        check("reset mem_we",    32'(mem_we),    32'd0);
        check("reset mem_addr",  32'(mem_addr),  32'd0);
        check("reset mem_wdata", mem_wdata,      32'd0);
        rst = 1'b0;

        apply_stimulus("pre SW w0", 1'b1, F3_W, 32'h0, 32'h0000_0000, 32'd0, 1'b0, 2, 1); check_output();
        apply_stimulus("pre SW w1", 1'b1, F3_W, 32'h4, 32'h0000_0001, 32'd0, 1'b0, 2, 1); check_output();
        apply_stimulus("pre SW w2", 1'b1, F3_W, 32'h8, 32'h0000_0002, 32'd0, 1'b0, 2, 1); check_output();
        apply_stimulus("pre SW w3", 1'b1, F3_W, 32'hC, 32'h8081_F0FF, 32'd0, 1'b0, 2, 1); check_output();

        apply_stimulus("LW 0x8",  1'b0, F3_W,  32'h8, 32'd0, 32'h0000_0002, 1'b0, 2, 0); check_output();
        apply_stimulus("SW 0x0",  1'b1, F3_W,  32'h0, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, 1); check_output();
        apply_stimulus("LW 0x0",  1'b0, F3_W,  32'h0, 32'd0, 32'hDEAD_BEEF, 1'b0, 2, 0); check_output();
        apply_stimulus("LB 0xC",  1'b0, F3_B,  32'hC, 32'd0, 32'hFFFF_FFFF, 1'b0, 2, 0); check_output();
        apply_stimulus("LBU 0xC", 1'b0, F3_BU, 32'hC, 32'd0, 32'h0000_00FF, 1'b0, 2, 0); check_output();
        apply_stimulus("LB 0xD",  1'b0, F3_B,  32'hD, 32'd0, 32'hFFFF_FFF0, 1'b0, 2, 0); check_output();
        apply_stimulus("LBU 0xE", 1'b0, F3_BU, 32'hE, 32'd0, 32'h0000_0081, 1'b0, 2, 0); check_output();
        apply_stimulus("LH 0xE",  1'b0, F3_H,  32'hE, 32'd0, 32'hFFFF_8081, 1'b0, 2, 0); check_output();
        apply_stimulus("LHU 0xE", 1'b0, F3_HU, 32'hE, 32'd0, 32'h0000_8081, 1'b0, 2, 0); check_output();
        apply_stimulus("LHU 0xC", 1'b0, F3_HU, 32'hC, 32'd0, 32'h0000_F0FF, 1'b0, 2, 0); check_output();
        apply_stimulus("SB 0x7",  1'b1, F3_B,  32'h7, 32'h0000_0055, 32'd0, 1'b0, 3, 1); check_output();
        apply_stimulus("LW 0x4",  1'b0, F3_W,  32'h4, 32'd0, 32'h5500_0001, 1'b0, 2, 0); check_output();
        apply_stimulus("SH 0xA",  1'b1, F3_H,  32'hA, 32'hFFFF_ABCD, 32'd0, 1'b0, 3, 1); check_output();
        apply_stimulus("LW 0x8b", 1'b0, F3_W,  32'h8, 32'd0, 32'hABCD_0002, 1'b0, 2, 0); check_output();

        apply_stimulus("err LW 0x6",  1'b0, F3_W,   32'h6, 32'd0, 32'd0, 1'b1, 1, 0); check_output();
        apply_stimulus("err SH 0x9",  1'b1, F3_H,   32'h9, 32'h1111, 32'd0, 1'b1, 1, 0); check_output();
        apply_stimulus("err LD f011", 1'b0, 3'b011, 32'h0, 32'd0, 32'd0, 1'b1, 1, 0); check_output();
        apply_stimulus("LW 0x4b",     1'b0, F3_W,   32'h4, 32'd0, 32'h5500_0001, 1'b0, 2, 0); check_output();

        // SH whose write cycle is cut short by reset.
        @(negedge clk);
        check("rst SH ready", 32'(ready), 32'd1);
        req    = 1'b1;
        we     = 1'b1;
        funct3 = F3_H;
        addr   = 32'h0;
        wdata  = 32'h0000_1234;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("rst SH st_read we", 32'(mem_we), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst SH st_write we", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        check("rst SH we gated", 32'(mem_we), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst SH ready low",  32'(ready),    32'd0);
        check("rst SH rdata",      rdata,         32'd0);
        check("rst SH done",       32'(done),     32'd0);
        check("rst SH err",        32'(err),      32'd0);
        check("rst SH mem_addr",   32'(mem_addr), 32'd0);
        check("rst SH mem_wdata",  mem_wdata,     32'd0);
        rst = 1'b0;
        last_rdata = 32'd0;
        @(negedge clk);
        check("rst SH ready after", 32'(ready), 32'd1);
        apply_stimulus("LW 0x0 post", 1'b0, F3_W, 32'h0, 32'd0, 32'hDEAD_BEEF, 1'b0, 2, 0); check_output();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
